framebuffer: RTL and testbench
==============================

# framebuffer

Single-port 4-bit gray-scale frame buffer serving the VGA driver's pixel-fetch interface: it presents the current pixel on `frame_pixel_out`, advances on each rising edge of `frame_next_pixel_in`, and rewinds on `frame_reset_in`. A valid/ready write port lets the GPU drawing logic update pixels. Display reads always win the memory over GPU writes. An optional line-repeat mode scales the stored image vertically.

## Interface
- `LINE_PIXELS`, 40: stored pixels per line.
- `LINES`, 30: stored lines.
- `LINE_REPEAT`, 4: display lines per stored line; used only with `FB_LINE_REPEAT_EN`.
- `DEPTH`, `LINE_PIXELS*LINES`: derived, not overridden.
- `ADDR_W`, `$clog2(DEPTH)`: derived.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `frame_next_pixel_in` input 1: rising edge = current pixel consumed, present the next one.
- `frame_reset_in` input 1: level; rewind the read pointer to address 0.
- `frame_pixel_out` output 4: current pixel, registered.
- `wr_valid_in` input 1: write request.
- `wr_ready_out` output 1: write accepted this cycle when high with `wr_valid_in`; combinational.
- `wr_addr_in` input ADDR_W: linear pixel address, row-major.
- `wr_data_in` input 4: gray value.

## Operation
- Edge detect: register `next_q` samples `frame_next_pixel_in` each cycle. `adv = frame_next_pixel_in & ~next_q`.
- Read pointer `ptr` (ADDR_W):
  - When `frame_reset_in` is high: `ptr <= 0` and `frame_pixel_out <= mem[0]` every cycle. `adv` is ignored.
  - Otherwise, on `adv`: `ptr <= nxt` and `frame_pixel_out <= mem[nxt]` in the same cycle.
- Linear mode: `nxt = (ptr == DEPTH-1) ? 0 : ptr+1`.
- Memory read cycle `rd = frame_reset_in | adv`.
- `wr_ready_out = ~rd`.
- Write handshake: a write fires when `wr_valid_in & wr_ready_out`. It then updates `mem[wr_addr_in]`.
  - An accepted write with `wr_addr_in >= DEPTH` is consumed and dropped.
  - An accepted write with `wr_addr_in == ptr` also loads `frame_pixel_out <= wr_data_in`. This is the coherence bypass.
- A pending write holds `wr_valid_in`, `wr_addr_in` and `wr_data_in` stable until it is accepted.
- Reset values (`rst_n` low, asynchronous):
  - `ptr=0`, `next_q=0`, `frame_pixel_out=0`.
  - Line-repeat state is 0.
  - `wr_ready_out` follows its equation.
  - Memory contents are not reset.
- If `frame_next_pixel_in` is high when reset releases, no advance occurs until it has gone low and then high again.

## Timing
- Advance latency: `frame_pixel_out` holds the new pixel 1 cycle after the first cycle `frame_next_pixel_in` is sampled high. A consumer sampling at least 2 cycles after its rising request edge always sees the new pixel.
- Rewind latency: `mem[0]` appears 1 cycle after `frame_reset_in` is first sampled high.
- Write latency: an accepted write is readable on the next cycle.
- Maximum stall: at most 1 cycle per display advance. During `frame_reset_in` high, writes are stalled for the whole pulse.
- Simultaneous events, in priority order:
  1. `rst_n`
  2. `frame_reset_in`
  3. `adv`
  4. write.
- Wrap-around: with `ptr = DEPTH-1`, an advance presents `mem[0]`.

## Configuration
- `FB_LINE_REPEAT_EN` defined:
  - Adds `col_ctr` (counts 0..LINE_PIXELS-1), `rep_ctr` (counts 0..LINE_REPEAT-1) and `line_base`.
  - On an advance with `col_ctr == LINE_PIXELS-1`:
    - If `rep_ctr != LINE_REPEAT-1`: `nxt = line_base` and `rep_ctr++`.
    - Otherwise: `rep_ctr = 0` and `line_base` steps by LINE_PIXELS, wrapping DEPTH to 0. `nxt` equals the new `line_base`.
  - On any other advance: `nxt = ptr+1` and `col_ctr++`.
  - `frame_reset_in` clears all three counters.
- `FB_LINE_REPEAT_EN` undefined: linear mode only; no repeat counters are synthesised.

## Structure
- Package `fb_pkg`:
  - `gray_t` (4-bit logic).
  - `fb_depth(lp, l)` and `fb_addr_w(lp, l)` constant functions.
- Sub-module `fb_ram`: DEPTH x 4 single-port synchronous-write, asynchronous-read array with one address mux. It is the one place to swap in a hard macro.
- Top level holds the edge detector, pointer/repeat logic, arbitration and bypass.

## Test plan
- Reset and rewind: fill `mem[i] = i%16`, then pulse `frame_reset_in` for 3 cycles. Require `frame_pixel_out = 0` one cycle later.
- Linear advance: apply 5 request pulses, each 3 cycles high and 3 low. Require outputs 1,2,3,4,5, each valid 1 cycle after its edge. A held-high request advances only once.
- Wrap-around: apply DEPTH advances from rewind. Require the output to return to `mem[0]`.
- Write arbitration: hold `wr_valid_in` high with address 7, data 0xA, in the same cycle as a request edge. Require `wr_ready_out = 0` that cycle, acceptance the next cycle, and a read-back of 0xA at address 7.
- Bypass: write address = `ptr`, data 0xF, with no advance. Require `frame_pixel_out = 0xF` the next cycle. An out-of-range address (>= DEPTH) is accepted, and `mem` is unchanged.
- `FB_LINE_REPEAT_EN` with `LINE_PIXELS=4`, `LINE_REPEAT=2`: apply 16 advances from rewind. Require address sequence 1,2,3,0,1,2,3,4,5,6,7,4,5,6,7,8.

Source files
------------

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared types and elaboration-time helpers for the framebuffer block.
//   gray_t      : 4-bit gray-scale pixel value
//   fb_depth    : number of stored pixels for a given line width / line count
//   fb_addr_w   : address width needed to index that many pixels
//   fb_cnt_w    : register width for a counter running 0..n-1 (minimum 1 bit)
// -----------------------------------------------------------------------------
package fb_pkg;

  typedef logic [3:0] gray_t;

  function automatic int fb_depth(input int lp, input int l);
    return lp * l;
  endfunction

  function automatic int fb_addr_w(input int lp, input int l);
    return (lp * l > 1) ? $clog2(lp * l) : 1;
  endfunction

  function automatic int fb_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : fb_pkg

// File: rtl/fb_ram.sv
// -----------------------------------------------------------------------------
// fb_ram
// DEPTH x 4 single-port pixel store: synchronous write, asynchronous read,
// one shared address. This is the only place that owns the storage array,
// so a hard memory macro can be dropped in here without touching the top.
// Ports:
//   clk      : clock
//   we_i     : write enable (addr_i must be < DEPTH when high)
//   addr_i   : shared read/write address
//   wdata_i  : write data
//   rdata_o  : read data at addr_i (combinational)
// -----------------------------------------------------------------------------
module fb_ram
  import fb_pkg::*;
#(
  parameter int DEPTH  = 1200,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  gray_t             wdata_i,
  output gray_t             rdata_o
);

  gray_t mem_q [DEPTH];

  // NOTE: the pixel array has no reset; clearing it would turn a plain RAM
  // into a huge flop bank with a reset tree, and contents are defined by the
  // GPU writes anyway.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule : fb_ram

// File: rtl/framebuffer.sv
// -----------------------------------------------------------------------------
// framebuffer
// Single-port 4-bit gray-scale frame buffer for the VGA pixel-fetch interface.
// The display side owns the memory whenever it reads (rewind or advance); the
// GPU valid/ready write port only gets the memory in the remaining cycles.
// A write that hits the pixel currently on display is bypassed straight into
// frame_pixel_out so the output never shows stale data.
//
// Optional feature: define FB_LINE_REPEAT_EN to repeat each stored line
// LINE_REPEAT times (vertical scaling). Without it the read pointer walks
// the memory linearly and no repeat counters exist.
//
// Ports:
//   clk                 : clock
//   rst_n               : asynchronous active-low reset
//   frame_next_pixel_in : rising edge advances to the next pixel
//   frame_reset_in      : level, rewinds the read pointer to address 0
//   frame_pixel_out     : current pixel (registered)
//   wr_valid_in         : write request
//   wr_ready_out        : write accepted this cycle (combinational)
//   wr_addr_in          : linear row-major pixel address
//   wr_data_in          : gray value to write
// -----------------------------------------------------------------------------
module framebuffer
  import fb_pkg::*;
#(
  parameter  int LINE_PIXELS = 40,
  parameter  int LINES       = 30,
  parameter  int LINE_REPEAT = 4,
  localparam int DEPTH       = fb_depth(LINE_PIXELS, LINES),
  localparam int ADDR_W      = fb_addr_w(LINE_PIXELS, LINES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_next_pixel_in,
  input  logic              frame_reset_in,
  output logic [3:0]        frame_pixel_out,
  input  logic              wr_valid_in,
  output logic              wr_ready_out,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [3:0]        wr_data_in
);

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

  if (LINE_PIXELS < 1 || LINES < 1 || LINE_REPEAT < 1) begin : g_bad_cfg
    $error("framebuffer: LINE_PIXELS, LINES and LINE_REPEAT must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Request edge detection
  // ---------------------------------------------------------------------------
  logic  next_q;
  logic  armed_q;   // set once the request has been seen low after reset
  logic  adv;
  logic  rd;

  // A request line still high when reset releases must not count as an edge,
  // so advancing is only armed after the line has been observed low.
  assign adv = frame_next_pixel_in & ~next_q & armed_q;
  assign rd  = frame_reset_in | adv;

  // ---------------------------------------------------------------------------
  // Write arbitration: display reads always win the single memory port
  // ---------------------------------------------------------------------------
  logic  wr_fire;
  logic  wr_in_range;

  assign wr_ready_out = ~rd;
  assign wr_fire      = wr_valid_in & ~rd;
  // Out-of-range writes are still handshaken, just never reach the array.
  assign wr_in_range  = (wr_addr_in <= LAST_ADDR);

  // ---------------------------------------------------------------------------
  // Next read address
  // ---------------------------------------------------------------------------
  addr_t ptr_q, ptr_d;
  addr_t nxt;

`ifdef FB_LINE_REPEAT_EN
  localparam int COL_W = fb_cnt_w(LINE_PIXELS);
  localparam int REP_W = fb_cnt_w(LINE_REPEAT);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_PIXELS - 1);
  localparam logic [REP_W-1:0] REP_LAST  = REP_W'(LINE_REPEAT - 1);
  localparam addr_t            BASE_LAST = addr_t'(DEPTH - LINE_PIXELS);

  logic [COL_W-1:0] col_q, col_d;
  logic [REP_W-1:0] rep_q, rep_d;
  addr_t            base_q, base_d;
  addr_t            base_step;

  // At the end of a displayed line either replay the same stored line
  // (jump back to line_base) or, after the last repeat, move to the next
  // stored line, wrapping to the top of the frame.
  always_comb begin
    col_d     = col_q;
    rep_d     = rep_q;
    base_d    = base_q;
    base_step = (base_q == BASE_LAST) ? '0 : base_q + addr_t'(LINE_PIXELS);
    nxt       = ptr_q + addr_t'(1);

    if (col_q == COL_LAST) begin
      nxt = (rep_q != REP_LAST) ? base_q : base_step;
    end

    if (frame_reset_in) begin
      col_d  = '0;
      rep_d  = '0;
      base_d = '0;
    end else if (adv) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (rep_q != REP_LAST) begin
          rep_d = rep_q + REP_W'(1);
        end else begin
          rep_d  = '0;
          base_d = base_step;
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      rep_q  <= '0;
      base_q <= '0;
    end else begin
      col_q  <= col_d;
      rep_q  <= rep_d;
      base_q <= base_d;
    end
  end
`else
  always_comb begin
    nxt = (ptr_q == LAST_ADDR) ? '0 : ptr_q + addr_t'(1);
  end
`endif

  // ---------------------------------------------------------------------------
  // Memory
  // ---------------------------------------------------------------------------
  addr_t ram_addr;
  logic  ram_we;
  gray_t ram_rdata;

  assign ram_we   = wr_fire & wr_in_range;
  assign ram_addr = frame_reset_in ? '0 :
                    adv            ? nxt :
                                     wr_addr_in;

  fb_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wr_data_in),
    .rdata_o (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Pointer and output pixel
  // ---------------------------------------------------------------------------
  gray_t pixel_q, pixel_d;

  always_comb begin
    ptr_d   = ptr_q;
    pixel_d = pixel_q;
    if (frame_reset_in) begin
      ptr_d   = '0;
      pixel_d = ram_rdata;
    end else if (adv) begin
      ptr_d   = nxt;
      pixel_d = ram_rdata;
    end else if (wr_fire && (wr_addr_in == ptr_q)) begin
      // Coherence bypass: the pixel on display was just overwritten.
      pixel_d = wr_data_in;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_q  <= 1'b0;
      armed_q <= 1'b0;
      ptr_q   <= '0;
      pixel_q <= '0;
    end else begin
      next_q  <= frame_next_pixel_in;
      armed_q <= armed_q | ~frame_next_pixel_in;
      ptr_q   <= ptr_d;
      pixel_q <= pixel_d;
    end
  end

  assign frame_pixel_out = pixel_q;

endmodule : framebuffer

// File: tb/tb_framebuffer.sv
// -----------------------------------------------------------------------------
// tb_framebuffer
// Self-checking bench for framebuffer. Keeps its own copy of the pixel store
// and derives the displayed address from the number of advances since the
// last rewind. Build with FB_LINE_REPEAT_EN defined to exercise line repeat
// (small 4x5 frame, 2 repeats).
// -----------------------------------------------------------------------------
module tb_framebuffer;

`ifdef FB_LINE_REPEAT_EN
  localparam int LP = 4;
  localparam int LN = 5;
  localparam int LR = 2;
  localparam int SWEEP = LP * LN * LR;
`else
  localparam int LP = 40;
  localparam int LN = 30;
  localparam int LR = 4;
  localparam int SWEEP = LP * LN;
`endif
  localparam int DEPTH = LP * LN;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_next_pixel_in;
  logic          frame_reset_in;
  logic [3:0]    frame_pixel_out;
  logic          wr_valid_in;
  logic          wr_ready_out;
  logic [AW-1:0] wr_addr_in;
  logic [3:0]    wr_data_in;

  framebuffer #(
    .LINE_PIXELS (LP),
    .LINES       (LN),
    .LINE_REPEAT (LR)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .frame_next_pixel_in (frame_next_pixel_in),
    .frame_reset_in      (frame_reset_in),
    .frame_pixel_out     (frame_pixel_out),
    .wr_valid_in         (wr_valid_in),
    .wr_ready_out        (wr_ready_out),
    .wr_addr_in          (wr_addr_in),
    .wr_data_in          (wr_data_in)
  );

  always #5 clk = ~clk;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [3:0] mem_m [DEPTH];
  int         adv_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stored address shown after n advances from a rewind.
  function automatic int addr_of(input int n);
`ifdef FB_LINE_REPEAT_EN
    return (((n / LP) / LR) % LN) * LP + (n % LP);
`else
    return n % DEPTH;
`endif
  endfunction

  function automatic logic [3:0] exp_pix();
    return mem_m[addr_of(adv_n)];
  endfunction

  task automatic rewind(input int cyc);
    @(posedge clk); #1;
    frame_reset_in = 1'b1;
    #1 check("rewind_stall", wr_ready_out, 1'b0);
    repeat (cyc) begin
      @(posedge clk); #1;
      check("rewind_pix", frame_pixel_out, mem_m[0]);
    end
    frame_reset_in = 1'b0;
    adv_n = 0;
  endtask

  // One request pulse: hi cycles high, lo cycles low.
  task automatic pulse_adv(input int hi, input int lo);
    @(posedge clk); #1;
    frame_next_pixel_in = 1'b1;
    #1 check("adv_stall", wr_ready_out, 1'b0);
    @(posedge clk); #1;
    adv_n++;
    check("adv_pix", frame_pixel_out, exp_pix());
    for (int i = 1; i < hi; i++) begin
      @(posedge clk); #1;
      check("held_pix", frame_pixel_out, exp_pix());
      check("held_ready", wr_ready_out, 1'b1);
    end
    frame_next_pixel_in = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  // Single-cycle write while the display side is idle.
  task automatic write_px(input int addr, input logic [3:0] data);
    @(posedge clk); #1;
    wr_valid_in = 1'b1;
    wr_addr_in  = AW'(addr);
    wr_data_in  = data;
    #1 check("wr_ready", wr_ready_out, 1'b1);
    @(posedge clk); #1;
    wr_valid_in = 1'b0;
    if (addr < DEPTH) mem_m[addr] = data;
    check("wr_pix", frame_pixel_out, exp_pix());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [16];
    int guard;
    logic [3:0] d;

    for (int i = 0; i < DEPTH; i++) mem_m[i] = 4'h0;
    rst_n               = 1'b0;
    frame_next_pixel_in = 1'b0;
    frame_reset_in      = 1'b0;
    wr_valid_in         = 1'b0;
    wr_addr_in          = '0;
    wr_data_in          = 4'h0;

    #12;
    check("rst_pix", frame_pixel_out, 4'h0);
    check("rst_ready", wr_ready_out, 1'b1);
    #11 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Fill mem[i] = i % 16, then rewind.
    for (int i = 0; i < DEPTH; i++) write_px(i, 4'(i % 16));
    rewind(3);
    check("rewind_zero", frame_pixel_out, 4'h0);

`ifdef FB_LINE_REPEAT_EN
    seq = '{1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7, 8};
    for (int k = 0; k < 16; k++) begin
      pulse_adv(1, 1);
      check("repeat_seq", frame_pixel_out, 4'(seq[k]));
    end
`else
    seq = '{default: 0};
    for (int k = 1; k <= 5; k++) begin
      pulse_adv(3, 3);
      check("linear_seq", frame_pixel_out, 4'(k));
    end
`endif

    // Write arbitration against a request edge.
    rewind(1);
    @(posedge clk); #1;
    frame_next_pixel_in = 1'b1;
    wr_valid_in = 1'b1;
    wr_addr_in  = AW'(7);
    wr_data_in  = 4'hA;
    #1 check("arb_stall", wr_ready_out, 1'b0);
    @(posedge clk); #1;
    adv_n++;
    check("arb_adv_pix", frame_pixel_out, exp_pix());
    check("arb_accept", wr_ready_out, 1'b1);
    @(posedge clk); #1;
    wr_valid_in = 1'b0;
    frame_next_pixel_in = 1'b0;
    mem_m[7] = 4'hA;
    rewind(1);
    guard = 0;
    while (addr_of(adv_n) != 7 && guard < SWEEP) begin
      pulse_adv(1, 1);
      guard++;
    end
    check("arb_readback", frame_pixel_out, 4'hA);

    // Bypass onto the displayed pixel, then an out-of-range write.
    write_px(addr_of(adv_n), 4'hF);
    check("bypass", frame_pixel_out, 4'hF);
    write_px(DEPTH + int'($urandom_range(0, (1 << AW) - 1 - DEPTH)), 4'h5);
    check("oor_pix", frame_pixel_out, 4'hF);

    // Randomized mix of writes, advances and rewinds.
    for (int n = 0; n < 400; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      d  = 4'($urandom);
      if (op == 0) begin
        rewind(int'($urandom_range(1, 3)));
      end else if (op <= 4) begin
        if ($urandom_range(0, 7) == 0)
          write_px(DEPTH + int'($urandom_range(0, (1 << AW) - 1 - DEPTH)), d);
        else
          write_px(int'($urandom_range(0, DEPTH - 1)), d);
      end else if (op <= 8) begin
        pulse_adv(int'($urandom_range(1, 3)), int'($urandom_range(1, 2)));
      end else begin
        write_px(addr_of(adv_n), d);
        check("rand_bypass", frame_pixel_out, d);
      end
    end

    // Full sweep: every address against the model, ending back at mem[0].
    rewind(1);
    for (int k = 0; k < SWEEP; k++) pulse_adv(1, 1);
    check("wrap", frame_pixel_out, mem_m[0]);

    // Request held high across reset must not advance.
    @(posedge clk); #1;
    frame_next_pixel_in = 1'b1;
    rst_n = 1'b0;
    #2 check("rst2_pix", frame_pixel_out, 4'h0);
    #4 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst2_hold", frame_pixel_out, 4'h0);
    end
    frame_next_pixel_in = 1'b0;
    adv_n = 0;
    pulse_adv(2, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_framebuffer
